// File: rtl/spi_frame_master_if.sv
// Host handshake and SPI pins of spi_frame_master, grouped in one bundle.
// The master modport is the initiator; the slave modport is the host and target side.
interface spi_frame_master_if #(
  parameter int FRAME_W = 40
);
  logic               start;
  logic               sel_in;
  logic [FRAME_W-1:0] tx_data;
  logic               busy;
  logic               done;
  logic [FRAME_W-1:0] rx_data;
  logic               spi_sel;
  logic               cs_b;
  logic               mosi;
  logic               miso;

  modport master (
    input  start, sel_in, tx_data, miso,
    output busy, done, rx_data, spi_sel, cs_b, mosi
  );

  modport slave (
    output start, sel_in, tx_data, miso,
    input  busy, done, rx_data, spi_sel, cs_b, mosi
  );
endinterface

// File: rtl/spi_frame_master.sv
// SPI initiator for the on-chip two-channel shift-register target: one FRAME_W-bit
// exchange per start, MSB first, on the shared clk; rx_data returns the channel's previous word.
module spi_frame_master #(
  parameter int FRAME_W    = 40,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_b,
  spi_frame_master_if.master  bus
);

  localparam int CNT_W = $clog2(FRAME_W);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [GAP_W-1:0]   gap_q,     gap_d;
  logic [FRAME_W-1:0] tx_sh_q,   tx_sh_d;
  logic [FRAME_W-1:0] rx_sh_q,   rx_sh_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               spi_sel_q, spi_sel_d;
  logic               cs_b_q,    cs_b_d;
  logic               mosi_q,    mosi_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic [FRAME_W-1:0] rx_next;

  // The word as it stands after this edge's miso bit is taken in.
  assign rx_next = (rx_sh_q << 1) | FRAME_W'(bus.miso);

  always_comb begin
    // NOTE: every next-state signal starts from its held value so no branch of the case can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    spi_sel_d = spi_sel_q;
    cs_b_d    = cs_b_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_sh_d   = bus.tx_data;
          spi_sel_d = bus.sel_in;
          mosi_d    = bus.tx_data[FRAME_W-1];
          cs_b_d    = 1'b0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        rx_sh_d = rx_next;
        tx_sh_d = tx_sh_q << 1;
        mosi_d  = tx_sh_q[FRAME_W-2];
        if (cnt_q == CNT_LAST) begin
          // Last edge with cs_b low; the counter is left at its final value rather than wrapping.
          cs_b_d    = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_next;
          done_d    = 1'b1;
          gap_d     = '0;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every register samples its peers' pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      spi_sel_q <= 1'b0;
      cs_b_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      spi_sel_q <= spi_sel_d;
      cs_b_q    <= cs_b_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.spi_sel = spi_sel_q;
  assign bus.cs_b    = cs_b_q;
  assign bus.mosi    = mosi_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: a two-channel shift-register target plus a per-channel
// "last word written" reference model, driven by directed and random frames.
module tb_spi_frame_master;

  localparam int FW     = 40;
  localparam int GAP    = 2;
  localparam int PERIOD = FW + GAP + 1;
  localparam int NF     = 4;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;

  spi_frame_master_if #(.FRAME_W(FW)) bus ();

  spi_frame_master #(.FRAME_W(FW), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Target: one shift register per channel, shifting on every clk edge while cs_b is low.
  logic [FW-1:0] tgt0 = '0;
  logic [FW-1:0] tgt1 = '0;
  assign bus.miso = bus.spi_sel ? tgt1[FW-1] : tgt0[FW-1];

  always @(posedge clk) begin
    if (bus.cs_b === 1'b0) begin
      if (bus.spi_sel) tgt1 <= {tgt1[FW-2:0], bus.mosi};
      else             tgt0 <= {tgt0[FW-2:0], bus.mosi};
    end
  end

  // Edge monitor: running totals only, read as snapshots by the stimulus.
  int   low_total   = 0;
  int   done_total  = 0;
  int   sel_toggles = 0;
  int   frame_edge  = 0;
  logic mosi_hist [FW+1];
  logic prev_cs_b = 1'b1;
  logic prev_sel  = 1'b0;

  always @(posedge clk) begin
    if (bus.cs_b === 1'b0) begin
      frame_edge = frame_edge + 1;
      low_total  = low_total + 1;
      if (frame_edge <= FW) mosi_hist[frame_edge] = bus.mosi;
      if (prev_cs_b === 1'b0 && bus.spi_sel !== prev_sel) sel_toggles = sel_toggles + 1;
    end else begin
      frame_edge = 0;
    end
    if (bus.done === 1'b1) done_total = done_total + 1;
    prev_cs_b = bus.cs_b;
    prev_sel  = bus.spi_sel;
  end

  // Reference model: each channel simply remembers the last word sent to it.
  logic [FW-1:0] ref_mem [2];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] rand_word();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[FW-1:0];
  endfunction

  // One frame; optionally pulses a stray start at negedge intrude_at, or resets at negedge reset_at.
  task automatic run_frame(input logic s, input logic [FW-1:0] d,
                           input int intrude_at, input int reset_at);
    int lt0;
    int dt0;
    int got;
    logic [FW-1:0] exp_rx;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.sel_in  = s;
    bus.tx_data = d;
    exp_rx = ref_mem[s];
    lt0    = low_total;
    dt0    = done_total;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.sel_in  = ~s;
    bus.tx_data = rand_word();
    check("busy_after_accept", FW'(bus.busy), FW'(1));
    check("cs_b_after_accept", FW'(bus.cs_b), FW'(0));
    got = 0;
    for (int i = 2; i <= FW + 10; i++) begin
      @(negedge clk);
      bus.start = (i == intrude_at);
      if (i == intrude_at) begin
        bus.sel_in  = ~s;
        bus.tx_data = ~d;
      end
      if (i == reset_at) begin
        rst_b = 1'b0;
        #1;
        check("rst_cs_b", FW'(bus.cs_b), FW'(1));
        check("rst_rx_data", bus.rx_data, '0);
        check("rst_busy", FW'(bus.busy), FW'(0));
        check("rst_done", FW'(bus.done), FW'(0));
        @(negedge clk);
        rst_b = 1'b1;
        check("rst_no_done", FW'(done_total - dt0), FW'(0));
        check("rst_low_edges", FW'(low_total - lt0), FW'(i - 1));
        // The target keeps the i-1 bits it has already shifted in.
        ref_mem[s] = (ref_mem[s] << (i - 1)) | (d >> (FW - (i - 1)));
        return;
      end
      if (bus.done === 1'b1) begin
        got = i;
        break;
      end
    end
    bus.start = 1'b0;
    check("done_latency", FW'(got), FW'(FW + 1));
    check("rx_data", bus.rx_data, exp_rx);
    check("spi_sel", FW'(bus.spi_sel), FW'(s));
    @(negedge clk);
    check("done_single", FW'(bus.done), FW'(0));
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.busy === 1'b0) begin
        got = i;
        break;
      end
      @(negedge clk);
    end
    check("busy_tail", FW'(got), FW'(GAP));
    check("done_count", FW'(done_total - dt0), FW'(1));
    check("cs_low_edges", FW'(low_total - lt0), FW'(FW));
    ref_mem[s] = d;
  endtask

  logic [FW-1:0] hold_exp [NF];

  initial begin
    int ones;
    int got;
    logic hs;
    logic [FW-1:0] hd;
    logic exp_done;
    ref_mem[0]  = '0;
    ref_mem[1]  = '0;
    bus.start   = 1'b0;
    bus.sel_in  = 1'b0;
    bus.tx_data = '0;

    repeat (3) @(negedge clk);
    check("reset_cs_b", FW'(bus.cs_b), FW'(1));
    check("reset_mosi", FW'(bus.mosi), FW'(0));
    check("reset_spi_sel", FW'(bus.spi_sel), FW'(0));
    check("reset_busy", FW'(bus.busy), FW'(0));
    check("reset_done", FW'(bus.done), FW'(0));
    check("reset_rx_data", bus.rx_data, '0);
    rst_b = 1'b1;

    // Basic pair on channel 0.
    run_frame(1'b0, 40'h12_3456_789A, 0, 0);
    run_frame(1'b0, 40'hAA_5555_AAAA, 0, 0);

    // Channel isolation.
    run_frame(1'b1, 40'hFF_0000_00FF, 0, 0);
    run_frame(1'b0, 40'h01_0203_0405, 0, 0);
    run_frame(1'b1, rand_word(), 0, 0);
    run_frame(1'b0, rand_word(), 0, 0);

    // Random frames.
    for (int k = 0; k < 4; k++) run_frame(1'($urandom_range(1)), rand_word(), 0, 0);

    // start held high with inputs changing every cycle.
    for (int c = 0; c <= (NF - 1) * PERIOD + FW + 1; c++) begin
      @(negedge clk);
      exp_done = (c >= FW + 1) && ((c - (FW + 1)) % PERIOD == 0);
      check("hold_done", FW'(bus.done), FW'(exp_done));
      if (exp_done) check("hold_rx_data", bus.rx_data, hold_exp[(c - (FW + 1)) / PERIOD]);
      hs = 1'($urandom_range(1));
      hd = rand_word();
      bus.start   = (c != (NF - 1) * PERIOD + FW + 1);
      bus.sel_in  = hs;
      bus.tx_data = hd;
      if (c % PERIOD == 0) begin
        hold_exp[c / PERIOD] = ref_mem[hs];
        ref_mem[hs] = hd;
      end
    end
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        got = 1;
        break;
      end
    end
    check("hold_returns_idle", FW'(got), FW'(1));
    run_frame(1'b0, rand_word(), 0, 0);
    run_frame(1'b1, rand_word(), 0, 0);

    // Stray start mid-frame is ignored; read-back shows the original word landed.
    run_frame(1'b0, rand_word(), 11, 0);
    run_frame(1'b0, rand_word(), 0, 0);

    // Reset after 17 bits, then normal frames recover.
    run_frame(1'b1, rand_word(), 0, 18);
    run_frame(1'b1, rand_word(), 0, 0);
    run_frame(1'b1, rand_word(), 0, 0);

    // Bit order.
    run_frame(1'b0, 40'h80_0000_0001, 0, 0);
    ones = 0;
    for (int k = 1; k <= FW; k++) ones += int'(mosi_hist[k]);
    check("mosi_first_bit", FW'(mosi_hist[1]), FW'(1));
    check("mosi_last_bit", FW'(mosi_hist[FW]), FW'(1));
    check("mosi_ones", FW'(ones), FW'(2));
    check("target_word", tgt0, 40'h80_0000_0001);
    check("sel_stable_low", FW'(sel_toggles), FW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
- SPI initiator that drives the on-chip two-channel SPI shift-register target.
- Sends one FRAME_W-bit word MSB-first on mosi and captures miso on the same edges, so rx_data holds the selected channel's previous contents.
- Sits between the control FSM / host bridge and the target. Uses the same clk as the target; there is no separate SCK and the target shifts on every clk edge while cs_b is low.

Parameters:
- FRAME_W, 40: bits per frame; must be ≥2.
- GAP_CYCLES, 2: minimum cycles cs_b stays high after a frame before the next start is accepted; must be ≥1.

Ports:
- clk  input  1  system clock, shared with the SPI target.
- rst_b  input  1  reset, asynchronous assert, active-low.
- start  input  1  request a frame; sampled only in IDLE.
- sel_in  input  1  channel select for the requested frame.
- tx_data  input  FRAME_W  word to send; latched at accept.
- busy  output  1  high from the cycle after accept until return to IDLE.
- done  output  1  one-cycle pulse; rx_data is valid from that cycle.
- rx_data  output  FRAME_W  word captured from miso, MSB first received.
- spi_sel  output  1  registered channel select to the target.
- cs_b  output  1  registered chip select, active-low.
- mosi  output  1  registered serial data to the target.
- miso  input  1  serial data from the target; combinational on the target's side.

Behaviour:
- Reset (rst_b=0, asynchronous):
  - State goes to IDLE.
  - cs_b=1, mosi=0, spi_sel=0, busy=0, done=0, rx_data=0.
  - Bit counter and shift registers are cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - cs_b=1 and busy=0. spi_sel holds its last value.
  - At edge E0 with start=1:
    - tx_sh <= tx_data, spi_sel <= sel_in, mosi <= tx_data[FRAME_W-1], cs_b <= 0, cnt <= 0, busy <= 1.
    - State goes to SHIFT.
- SHIFT:
  - Spans edges E1..E_FRAME_W. At each edge, in parallel:
    - rx_sh <= {rx_sh[FRAME_W-2:0], miso}
    - tx_sh shifts left and mosi <= next bit
    - cnt increments
  - The target therefore captures mosi = tx_data[FRAME_W-k] at edge Ek.
  - At edge E_FRAME_W (cnt==FRAME_W-1):
    - cs_b <= 1, mosi <= 0.
    - rx_data <= {rx_sh[FRAME_W-2:0], miso}, done <= 1.
    - gap counter cleared; state goes to GAP.
  - Exactly FRAME_W edges see cs_b=0.
- GAP:
  - done lasts one cycle only.
  - After GAP_CYCLES cycles with cs_b=1, busy <= 0 and state goes to IDLE.
  - A start in the IDLE cycle right after GAP is accepted.
- Latency: start at E0 gives done high in the cycle after E_FRAME_W. busy is high for FRAME_W+GAP_CYCLES cycles.
- start, sel_in and tx_data are ignored outside IDLE. Changes to tx_data or sel_in mid-frame have no effect.
- spi_sel is stable for the whole time cs_b is low and through GAP. It only changes at accept.
- rx_data holds its value until the next done.
- Reset mid-frame:
  - cs_b rises immediately (asynchronous) and no done is produced.
  - rx_data returns to 0.
  - The target keeps a partially shifted word; this is not recovered.
- cnt width is clog2(FRAME_W). No wrap occurs, because the state exits at FRAME_W-1.

Test Plan:
- Reset release, then start with sel_in=0, tx_data=40'h12_3456_789A; then send a second frame 40'hAA_5555_AAAA to channel 0:
  - cs_b is low for exactly 40 edges per frame.
  - The first done shows rx_data=0.
  - The second done shows rx_data=40'h12_3456_789A.
  - done is a single pulse per frame.
- Channel isolation:
  - Write 40'hFF_0000_00FF to channel 1 and then 40'h01_0203_0405 to channel 0.
  - A read-back frame on channel 1 returns 40'hFF_0000_00FF.
  - A read-back frame on channel 0 returns 40'h01_0203_0405.
- Hold start=1 continuously with changing tx_data:
  - Frames are accepted every 40+GAP_CYCLES+1 cycles.
  - Each frame carries the tx_data value present at its accept edge.
  - spi_sel never toggles while cs_b=0.
- Pulse start in cycle 10 of SHIFT with a different tx_data and sel_in: the frame is ignored and the current frame completes unchanged.
- Assert rst_b=0 at bit 17:
  - cs_b=1 immediately; rx_data=0, busy=0, no done.
  - After release, a new frame completes normally with 40 edges.
- Bit-order check with tx_data=40'h80_0000_0001:
  - mosi=1 at E1 and at E40; mosi=0 at all other edges.
  - Scoreboard the target model's received word equals 40'h80_0000_0001.
